// File: rtl/l2_line_adaptor.sv
// Adapts 256-bit L2 line requests to four-beat 64-bit memory bursts.
// Optional macro LINE_ADAPTOR_POSTED_WRITE_EN: acknowledge writes at acceptance.
module l2_line_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic         burst_read,
  output logic         burst_write,
  output logic [31:0]  burst_address,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;
  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  // state | meaning
  // IDLE  | waiting for a line request
  // READ  | collecting read beats into line_rdata
  // WRITE | presenting write beats from the latched line
  // DONE  | one-cycle completion (line_resp unless the write was posted)
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       state;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic [255:0] wline;

  assign count_next = count + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= 2'd0;
      wline         <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
      burst_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          line_resp <= 1'b0;
          count     <= 2'd0;
          // write has priority when both requests are raised together
          if (line_write) begin
            burst_address <= {line_address[31:5], 5'b0};
            wline         <= line_wdata;
            burst_wdata   <= line_wdata[S_BURST-1:0];
            burst_write   <= 1'b1;
            state         <= WRITE;
`ifdef LINE_ADAPTOR_POSTED_WRITE_EN
            line_resp     <= 1'b1;
`endif
          end else if (line_read) begin
            burst_address <= {line_address[31:5], 5'b0};
            burst_read    <= 1'b1;
            state         <= READ;
          end
        end

        READ: begin
          if (burst_resp) begin
            line_rdata[int'(count)*S_BURST +: S_BURST] <= burst_rdata;
            if (count == LAST_BEAT) begin
              count      <= 2'd0;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              state      <= DONE;
            end else begin
              count <= count_next;
            end
          end
        end

        WRITE: begin
          line_resp <= 1'b0;
          if (burst_resp) begin
            if (count == LAST_BEAT) begin
              count       <= 2'd0;
              burst_write <= 1'b0;
              state       <= DONE;
`ifndef LINE_ADAPTOR_POSTED_WRITE_EN
              line_resp   <= 1'b1;
`endif
            end else begin
              count       <= count_next;
              burst_wdata <= wline[int'(count_next)*S_BURST +: S_BURST];
            end
          end
        end

        DONE: begin
          line_resp <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          line_resp   <= 1'b0;
          burst_read  <= 1'b0;
          burst_write <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Scoreboard bench for l2_line_adaptor: expected lines, beats and addresses are
// queued as requests are driven and popped when the DUT presents them.
module tb_l2_line_adaptor;

`ifdef LINE_ADAPTOR_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int checks = 0;
  int errors = 0;

  logic [255:0] q_line[$];
  logic [63:0]  q_beat[$];
  logic [31:0]  q_addr[$];
  logic [255:0] last_line;

  l2_line_adaptor dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({line_resp, burst_read, burst_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {line_resp, burst_read, burst_write});
    end
    checks++;
    if (line_rdata !== '0 || burst_address !== '0 || burst_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all zero",
               line_rdata, burst_address, burst_wdata);
    end
    last_line = '0;
  endtask

  // Drives one read; returns in the first IDLE cycle after line_resp with the request dropped.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line, input int waits);
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    line_address = addr;
    line_read    = 1'b1;
    q_line.push_back(line);
    q_addr.push_back({addr[31:5], 5'b0});
    tick;
    exp_addr = q_addr.pop_front();
    checks++;
    if (burst_address !== exp_addr) begin
      errors++;
      $display("FAIL rd_addr: got %h expected %h", burst_address, exp_addr);
    end
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < waits; w++) begin
        burst_resp = 1'b0;
        checks++;
        if ({burst_read, burst_write, line_resp} !== 3'b100) begin
          errors++;
          $display("FAIL rd_wait_flags beat %0d: got %b expected 100", k,
                   {burst_read, burst_write, line_resp});
        end
        tick;
      end
      burst_resp  = 1'b1;
      burst_rdata = line[64*k +: 64];
      checks++;
      if ({burst_read, burst_write, line_resp} !== 3'b100 || burst_address !== exp_addr) begin
        errors++;
        $display("FAIL rd_beat_flags beat %0d: got %b addr %h expected 100 addr %h", k,
                 {burst_read, burst_write, line_resp}, burst_address, exp_addr);
      end
      tick;
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    exp_line = q_line.pop_front();
    checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b001) begin
      errors++;
      $display("FAIL rd_resp_flags: got %b expected 001", {burst_read, burst_write, line_resp});
    end
    checks++;
    if (line_rdata !== exp_line) begin
      errors++;
      $display("FAIL rd_line: got %h expected %h", line_rdata, exp_line);
    end
    last_line = exp_line;
    tick;
    line_read = 1'b0;
    checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      errors++;
      $display("FAIL rd_after_resp: got %b expected 000", {burst_read, burst_write, line_resp});
    end
  endtask

  // Drives one write (optionally with line_read also high); returns in the first IDLE cycle.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input int waits,
                           input bit both);
    logic [31:0] exp_addr;
    logic [63:0] exp_beat;
    bit          first;
    line_address = addr;
    line_wdata   = line;
    line_write   = 1'b1;
    line_read    = both;
    for (int k = 0; k < 4; k++) q_beat.push_back(line[64*k +: 64]);
    q_addr.push_back({addr[31:5], 5'b0});
    tick;
    first = 1'b1;
    exp_addr = q_addr.pop_front();
    checks++;
    if (burst_address !== exp_addr) begin
      errors++;
      $display("FAIL wr_addr: got %h expected %h", burst_address, exp_addr);
    end
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < waits; w++) begin
        burst_resp = 1'b0;
        checks++;
        if ({burst_read, burst_write, line_resp} !== {2'b01, POSTED & first} ||
            burst_wdata !== q_beat[0]) begin
          errors++;
          $display("FAIL wr_wait beat %0d: got flags %b data %h expected %b data %h", k,
                   {burst_read, burst_write, line_resp}, burst_wdata,
                   {2'b01, POSTED & first}, q_beat[0]);
        end
        tick;
        first = 1'b0;
        if (POSTED) begin line_write = 1'b0; line_read = 1'b0; end
      end
      exp_beat = q_beat.pop_front();
      checks++;
      if ({burst_read, burst_write, line_resp} !== {2'b01, POSTED & first} ||
          burst_wdata !== exp_beat || burst_address !== exp_addr) begin
        errors++;
        $display("FAIL wr_beat %0d: got flags %b data %h addr %h expected %b data %h addr %h", k,
                 {burst_read, burst_write, line_resp}, burst_wdata, burst_address,
                 {2'b01, POSTED & first}, exp_beat, exp_addr);
      end
      burst_resp = 1'b1;
      tick;
      first = 1'b0;
      if (POSTED) begin line_write = 1'b0; line_read = 1'b0; end
    end
    burst_resp = 1'b0;
    checks++;
    if ({burst_read, burst_write, line_resp} !== {2'b00, !POSTED}) begin
      errors++;
      $display("FAIL wr_done_flags: got %b expected %b", {burst_read, burst_write, line_resp},
               {2'b00, !POSTED});
    end
    checks++;
    if (line_rdata !== last_line) begin
      errors++;
      $display("FAIL wr_rdata_kept: got %h expected %h", line_rdata, last_line);
    end
    tick;
    line_write = 1'b0;
    line_read  = 1'b0;
    checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      errors++;
      $display("FAIL wr_after_done: got %b expected 000", {burst_read, burst_write, line_resp});
    end
  endtask

  task automatic test_read_zero_wait;
    run_read(32'h0000_1234, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 0);
  endtask

  task automatic test_write_wait;
    run_write(32'h0000_2000, {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                              64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000}, 2, 1'b0);
  endtask

  task automatic test_both_high;
    run_write(32'h0000_3048, {64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF,
                              64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_5A5A_A5A5}, 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    line_address = 32'h0000_4000;
    line_read    = 1'b1;
    tick;
    for (int k = 0; k < 2; k++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(k);
      tick;
    end
    rst = 1'b1; line_read = 1'b0; burst_resp = 1'b0;
    tick;
    rst = 1'b0;
    checks++;
    if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== '0 ||
        burst_address !== '0 || burst_wdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got flags %b rdata %h addr %h wdata %h expected all zero",
               {line_resp, burst_read, burst_write}, line_rdata, burst_address, burst_wdata);
    end
    last_line = '0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if ({line_resp, burst_read, burst_write} !== 3'b000) begin
        errors++;
        $display("FAIL mid_reset_quiet cycle %0d: got %b expected 000", c,
                 {line_resp, burst_read, burst_write});
      end
    end
    run_read(32'h0000_4010, {64'h4, 64'h3, 64'h2, 64'h1} * 256'h0101, 1);
  endtask

  task automatic test_back_to_back;
    run_read(32'h0000_5000, {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000}, 0);
    run_write(32'h0000_6020, {64'hBEEF_0003, 64'hBEEF_0002, 64'hBEEF_0001, 64'hBEEF_0000}, 0, 1'b0);
  endtask

  task automatic test_spurious;
    for (int c = 0; c < 4; c++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      tick;
      checks++;
      if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== last_line) begin
        errors++;
        $display("FAIL spurious cycle %0d: got flags %b rdata %h expected 000 rdata %h", c,
                 {line_resp, burst_read, burst_write}, line_rdata, last_line);
      end
    end
    burst_resp = 1'b0;
    run_read(32'h0000_7000, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom}, 0);
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_wait;
    test_both_high;
    test_reset_mid;
    test_back_to_back;
    test_spurious;
    if (q_line.size() != 0 || q_beat.size() != 0 || q_addr.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d lines %0d beats %0d addrs left, expected 0",
               q_line.size(), q_beat.size(), q_addr.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
